// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: sync byte,
// error codes and FSM state encodings.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FRAMING = 3'd1;
  localparam logic [2:0] ERR_RANGE   = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_RUN,
    ST_ERROR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // States that belong to an open frame: timeout and framing errors apply here.
  function automatic logic in_frame(input ld_state_e s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_imem_loader_rx_byte.sv
// uart_rx_byte: 2-FF synchroniser plus 8N1 bit timing. Emits one byte with a
// single-cycle valid strobe, or a single-cycle framing-error strobe when the
// stop bit samples low (byte dropped). A start bit that is high again at its
// midpoint is treated as a glitch and produces nothing.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            fall;

  // Synchroniser and edge-detect history; line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  // Bit-timing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: half-bit start check, then mid-bit sampling of data and stop.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          st_d    = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = ~sync2_q;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_data_o      = sh_q;
  assign rx_valid_o     = valid_q;
  assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: receives A5 / count lo / count hi / words (LE) / [checksum]
// over UART and writes the words into instruction memory, holding the core in
// reset until the frame is accepted (or loading is disabled).
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
// ADDR_W is limited to 16 since the frame carries a 16-bit word count.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_i,
  input  logic              load_en_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        err_code_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_W);

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_e ST_AFTER_DATA = ST_CSUM;
`else
  localparam ld_state_e ST_AFTER_DATA = ST_DONE;
`endif

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (uart_rx_i),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_frame_err_o(rx_ferr)
  );

  ld_state_e         st_q, st_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       rem_q, rem_d;        // words still to be written
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        bsel_q, bsel_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [2:0]        code_q, code_d;
  logic              active;
  logic [15:0]       count;

  // Frame FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      cnt_lo_q <= '0;
      rem_q    <= '0;
      widx_q   <= '0;
      bsel_q   <= '0;
      wbuf_q   <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      st_q     <= st_d;
      cnt_lo_q <= cnt_lo_d;
      rem_q    <= rem_d;
      widx_q   <= widx_d;
      bsel_q   <= bsel_d;
      wbuf_q   <= wbuf_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      code_q   <= code_d;
    end
  end

  // Next-state: byte-driven frame parsing, then framing/timeout overrides
  // (both are mutually exclusive with rx_valid, so a byte always wins).
  always_comb begin
    st_d     = st_q;
    cnt_lo_d = cnt_lo_q;
    rem_d    = rem_q;
    bsel_d   = bsel_q;
    wbuf_d   = wbuf_q;
    csum_d   = csum_q;
    code_d   = code_q;
    we_d     = 1'b0;
    // Address advances the cycle after each write strobe.
    widx_d   = we_q ? widx_q + 1'b1 : widx_q;
    active   = in_frame(st_q);
    tmo_d    = (active && !rx_valid) ? tmo_q + 1'b1 : '0;
    count    = {rx_data, cnt_lo_q};

    case (st_q)
      ST_IDLE: begin
        if (!load_en_i) begin
          st_d = ST_RUN;
        end else if (rx_valid && rx_data == SYNC_BYTE) begin
          st_d   = ST_CNT_LO;
          csum_d = '0;
          widx_d = '0;
          bsel_d = '0;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_d = rx_data;
          csum_d   = csum_q ^ rx_data;
          st_d     = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          rem_d  = count;
          if ({1'b0, count} > MAX_WORDS) begin
            st_d   = ST_ERROR;
            code_d = ERR_RANGE;
          end else if (count == 16'd0) begin
            st_d = ST_AFTER_DATA;
          end else begin
            st_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          wbuf_d = {rx_data, wbuf_q[31:8]};
          bsel_d = bsel_q + 2'd1;
          if (bsel_q == 2'd3) begin
            we_d  = 1'b1;
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) st_d = ST_AFTER_DATA;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_data != csum_q) begin
            st_d   = ST_ERROR;
            code_d = ERR_CSUM;
          end else begin
            st_d = ST_DONE;
          end
        end
      end
`endif
      ST_ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          st_d   = ST_CNT_LO;
          code_d = ERR_NONE;
          csum_d = '0;
          widx_d = '0;
          bsel_d = '0;
        end
      end
      default: ;
    endcase

    if (active && rx_ferr) begin
      st_d   = ST_ERROR;
      code_d = ERR_FRAMING;
    end else if (active && !rx_valid && tmo_q == TMO_LAST) begin
      st_d   = ST_ERROR;
      code_d = ERR_TIMEOUT;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = widx_q;
  assign imem_wdata_o = wbuf_q;
  assign core_rst_o   = !((st_q == ST_DONE) || (st_q == ST_RUN));
  assign done_o       = (st_q == ST_DONE);
  assign err_o        = (st_q == ST_ERROR);
  assign err_code_o   = code_q;

endmodule
